// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the byte FIFO read port, the UART transmitter and its observers.
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  // Environment side: supplies enable and FIFO state, observes the line.
  modport master (
    output tx_en, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, tx_done
  );

  // Transmitter side.
  modport slave (
    input  tx_en, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmit stage draining a synchronous byte FIFO, LSB-first, with optional parity.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.slave  bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic          tx_q, tx_n;
  logic          rd_q, rd_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          baud_last;

  assign baud_last   = (cnt == CNT_LAST);
  assign bus.tx      = tx_q;
  assign bus.fifo_rd = rd_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      par_bit <= par_n;
      tx_q    <= tx_n;
      rd_q    <= rd_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state sequencing; outputs are derived from the state being entered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par_bit;
    done_n  = 1'b0;
    tx_n    = 1'b1;
    rd_n    = 1'b0;
    busy_n  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.tx_en && !bus.fifo_empty) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        shift_n = bus.fifo_data;
        par_n   = (PARITY == 2) ? ~^bus.fifo_data : ^bus.fifo_data;
        bit_n   = '0;
        cnt_n   = '0;
        state_n = S_START;
      end
      S_START: begin
        if (baud_last) begin
          cnt_n   = '0;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_n   = '0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
    rd_n   = (state_n == S_FETCH);
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: three transmitter configurations share stimulus and are checked per cycle.
module tb_fifo_uart_tx;
  localparam int NL = 3;
  localparam int CPB [NL] = '{4, 4, 3};
  localparam int PAR [NL] = '{0, 1, 2};
  localparam int STB [NL] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_en = 1'b0;

  logic [NL-1:0] tx_v, rd_v, busy_v, done_v;
  logic [NL-1:0] empty_v = '1;
  logic [7:0]    fdata [NL];

  logic [7:0] src [$];
  int rp [NL];
  int ep [NL];

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_if bus [NL] ();

  for (genvar g = 0; g < NL; g++) begin : lane
    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB[g]),
      .PARITY      (PAR[g]),
      .STOP_BITS   (STOP_BITS_OF(g))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[g])
    );
    assign bus[g].tx_en      = tx_en;
    assign bus[g].fifo_empty = empty_v[g];
    assign bus[g].fifo_data  = fdata[g];
    assign tx_v[g]   = bus[g].tx;
    assign rd_v[g]   = bus[g].fifo_rd;
    assign busy_v[g] = bus[g].busy;
    assign done_v[g] = bus[g].tx_done;
  end

  function automatic int STOP_BITS_OF(input int i);
    return STB[i];
  endfunction

  // Expected line level for serial bit slot k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par != 0) return (par == 1) ? ^b : ~^b;
    return 1'b1;
  endfunction

  function automatic int flen(input int i);
    return (9 + ((PAR[i] != 0) ? 1 : 0) + STB[i]) * CPB[i];
  endfunction

  task automatic chk(input logic ok, input string nm, input int ln, input longint act, input longint exp);
    ncmp++;
    if (!ok) begin
      nbad++;
      $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", nm, ln, $time, act, exp);
    end
  endtask

  // FIFO read port model: data appears the cycle after a sampled read.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (!rst && rd_v[i] && rp[i] < src.size()) begin
        fdata[i] <= src[rp[i]];
        rp[i]    <= rp[i] + 1;
      end
    end
  end

  // Monitor / scoreboard: compares every lane each cycle against the frame rules.
  int     cyc = 0;
  logic   en_p = 1'b0;
  logic   rst_p = 1'b1;
  logic   busy_p [NL];
  logic   empty_p [NL];
  logic   inf [NL];
  int     pos [NL];
  int     rd_since [NL];
  int     rd_cyc [NL];
  int     stall [NL];
  logic [7:0] cur [NL];

  initial begin
    for (int i = 0; i < NL; i++) begin
      rp[i] = 0; ep[i] = 0; busy_p[i] = 1'b0; empty_p[i] = 1'b1; inf[i] = 1'b0;
      pos[i] = 0; rd_since[i] = 0; rd_cyc[i] = 0; stall[i] = 0; cur[i] = 8'h00;
      fdata[i] = 8'h00;
    end
  end

  always @(negedge clk) begin
    logic exp_rd;
    logic b;
    cyc++;
    for (int i = 0; i < NL; i++) begin
      if (rst) begin
        chk({tx_v[i], rd_v[i], busy_v[i], done_v[i]} == 4'b1000, "reset_out", i,
            {tx_v[i], rd_v[i], busy_v[i], done_v[i]}, 4'b1000);
        inf[i] = 1'b0; ep[i] = rp[i]; rd_since[i] = 0; stall[i] = 0;
      end else begin
        exp_rd = !rst_p && !busy_p[i] && en_p && !empty_p[i];
        chk(rd_v[i] == exp_rd, "fifo_rd", i, rd_v[i], exp_rd);
        if (rd_v[i]) begin
          rd_since[i]++;
          rd_cyc[i] = cyc;
        end
        if (!inf[i] && !tx_v[i]) begin
          chk(rd_since[i] == 1 && cyc - rd_cyc[i] == 2, "start_latency", i,
              (rd_since[i] == 1) ? cyc - rd_cyc[i] : -rd_since[i], 2);
          chk(ep[i] < rp[i], "unexpected_frame", i, ep[i], rp[i]);
          if (ep[i] < src.size()) cur[i] = src[ep[i]];
          ep[i]++;
          rd_since[i] = 0;
          inf[i] = 1'b1;
          pos[i] = 0;
        end
        if (inf[i]) begin
          if (pos[i] < flen(i)) begin
            b = exp_bit(cur[i], PAR[i], pos[i] / CPB[i]);
            chk({tx_v[i], busy_v[i], done_v[i]} == {b, 2'b10}, "frame_bit", i,
                {tx_v[i], busy_v[i], done_v[i]}, {b, 2'b10});
          end else begin
            chk({tx_v[i], busy_v[i], done_v[i]} == 3'b101, "frame_end", i,
                {tx_v[i], busy_v[i], done_v[i]}, 3'b101);
            inf[i] = 1'b0;
          end
          pos[i]++;
          stall[i] = 0;
        end else begin
          chk(done_v[i] == 1'b0, "idle_done", i, done_v[i], 0);
          if (en_p && ep[i] < src.size()) begin
            stall[i]++;
            chk(stall[i] < 64, "stall", i, stall[i], 64);
          end else begin
            stall[i] = 0;
          end
        end
      end
      empty_v[i] = (rp[i] >= src.size());
      empty_p[i] = empty_v[i];
      busy_p[i]  = busy_v[i];
    end
    en_p  = tx_en;
    rst_p = rst;
  end

  function automatic logic all_idle();
    for (int i = 0; i < NL; i++)
      if (ep[i] < src.size() || busy_v[i] || inf[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while (!all_idle() && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rd0();
    int n = 0;
    while (!rd_v[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic cyc_step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int backlog;
    int minrp;
    #1 rst = 1'b1;
    // Reset held with data available and enable high: no reads.
    src.push_back(8'hA5);
    tx_en = 1'b1;
    cyc_step(4);
    rst = 1'b0;
    tx_en = 1'b0;
    // Enable gating: data present but tx_en low.
    cyc_step(50);
    tx_en = 1'b1;
    drain();

    // Back-to-back frames.
    cyc_step(1);
    src.push_back(8'h00);
    src.push_back(8'hFF);
    drain();

    // Parity patterns.
    cyc_step(1);
    src.push_back(8'h07);
    src.push_back(8'h03);
    drain();

    // Enable dropped mid-frame: frame finishes, next byte stays queued.
    cyc_step(1);
    src.push_back(8'h11);
    src.push_back(8'h22);
    wait_rd0();
    cyc_step(12);
    tx_en = 1'b0;
    cyc_step(150);
    tx_en = 1'b1;
    drain();

    // Asynchronous reset during a data bit: in-flight byte is dropped.
    cyc_step(1);
    src.push_back(8'h5A);
    src.push_back(8'h3C);
    wait_rd0();
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drain();

    // Randomized traffic with enable toggling.
    for (int k = 0; k < 2000; k++) begin
      cyc_step(1);
      minrp = rp[0];
      for (int i = 1; i < NL; i++) if (rp[i] < minrp) minrp = rp[i];
      backlog = src.size() - minrp;
      if ($urandom_range(0, 29) == 0 && backlog < 8) src.push_back(8'($urandom));
      tx_en = ($urandom_range(0, 15) != 0);
    end
    cyc_step(1);
    tx_en = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains bytes from the 8-deep synchronous byte FIFO and sends each one as an asynchronous UART frame on a single line. It sits directly downstream of the FIFO's read port. It issues one-cycle read strobes, captures the FIFO's registered read data one cycle later, and shifts the byte out LSB-first. Start bit, optional parity bit and stop bit(s) are generated from a parameterised per-bit clock count.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥2.
- PARITY, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_en  in  1  transmit enable; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data; valid the cycle after the FIFO samples a read.
- fifo_rd  out  1  FIFO read strobe; registered, one cycle per byte.
- tx  out  1  serial line, idle high; registered.
- busy  out  1  high whenever state ≠ IDLE; registered.
- tx_done  out  1  one-cycle pulse at completion of each frame; registered.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If tx_en=1 and fifo_empty=0 at an edge, go to FETCH with fifo_rd=1. Otherwise stay.
- FETCH: fifo_rd=1 for exactly this cycle. Go to LOAD unconditionally.
- LOAD: fifo_rd=0. At the edge, capture fifo_data into the 8-bit shift register, compute the parity bit, clear the bit counter, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index 0..7. After bit 7, go to PARITY if PARITY≠0, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles.
  - Even: parity bit = ^byte.
  - Odd: parity bit = ~^byte.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. On the final edge, pulse tx_done=1 for one cycle and return to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Forced to 0 on every state entry.
- tx_en deasserted mid-frame has no effect; the current frame completes and the next fetch is blocked.
- fifo_empty is ignored outside IDLE.
- The block never issues more than one fifo_rd per frame, so it never reads an empty FIFO.
- Reset, asserted at any time:
  - Immediately: state=IDLE, tx=1, fifo_rd=0, busy=0, tx_done=0, counters=0, shift register=0.
  - A frame in progress is truncated and its byte is discarded; it is not retransmitted.
- Bytes are transmitted in FIFO order, each exactly once.

## Timing
- Edge E0: IDLE samples tx_en=1 and fifo_empty=0.
- Cycle after E0: fifo_rd high (FETCH).
- Edge E1: FIFO samples rd.
- Cycle after E1: fifo_data valid (LOAD).
- Edge E2: byte captured, tx falls (start bit begins).
- Read-to-start latency: 2 cycles from the sampling edge E0 to tx falling.
- Frame length: (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, from tx falling to tx_done.
- tx_done coincides with the first IDLE cycle.
- Back-to-back frames with a non-empty FIFO: 3 extra idle-high cycles (IDLE, FETCH, LOAD) between the end of the stop bit and the next start bit.
- busy rises on the cycle fifo_rd rises and falls on the cycle tx_done pulses.

## Test plan
- Reset values: assert rst asynchronously mid-cycle with CLKS_PER_BIT=4 -> tx=1, fifo_rd=0, busy=0, tx_done=0 within the same cycle; hold with fifo_empty=0 -> no fifo_rd.
- Single byte: CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, FIFO holds 0xA5, tx_en=1 ->
  - exactly one fifo_rd pulse;
  - tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles;
  - tx_done 40 cycles after tx falls;
  - busy returns to 0.
- Back-to-back: FIFO holds 0x00 then 0xFF -> two fifo_rd pulses, frames in order, tx high for exactly 4+3=7 cycles between the 0x00 frame's start of stop bit and the 0xFF frame's start bit.
- Parity: PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> 0; PARITY=1 with 0x03 -> 0; frame length 44 cycles at CLKS_PER_BIT=4.
- Enable gating: fifo_empty=0, tx_en=0 -> no fifo_rd for 50 cycles. Raise tx_en -> fifo_rd next cycle. Drop tx_en during DATA -> frame completes, no further fifo_rd.
- Reset mid-frame: assert rst during data bit 3 of 0x5A, release 2 cycles later with FIFO still holding 0x3C -> tx=1 immediately, 0x5A not resent, next frame carries 0x3C.
